// File: rtl/btb_pkg.sv
// Shared types and constants for the BTB update controller.
// A zero target marks an empty table entry.
package btb_pkg;

  localparam int unsigned DEF_IDX_W  = 8;
  localparam int unsigned DEF_ADDR_W = 16;

  localparam logic [DEF_ADDR_W-1:0] BTB_INVALID = 16'h0000;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_ADDR_W-1:0] target;
    logic                  taken;
    logic                  inval;
  } upd_entry_t;

  // Table write data for a queued update.
  function automatic logic [DEF_ADDR_W-1:0] entry_wdata(input upd_entry_t e);
    return e.inval ? BTB_INVALID : e.target;
  endfunction

endpackage

// File: rtl/btb_update_ctrl_if.sv
// Update-request, table-write and status signals of the BTB update controller.
// The slave side is the controller; the master side is EX/MEM, IF and the table.
interface btb_update_ctrl_if #(
  parameter int unsigned IDX_W  = btb_pkg::DEF_IDX_W,
  parameter int unsigned ADDR_W = btb_pkg::DEF_ADDR_W
);

  logic              inv_req;
  logic              wr_hold;
  logic              upd_valid;
  logic              upd_ready;
  logic [ADDR_W-1:0] upd_pc;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_taken;
  logic              upd_inval;
  logic              btb_we;
  logic [IDX_W-1:0]  btb_waddr;
  logic [ADDR_W-1:0] btb_wdata;
  logic              bht_inc;
  logic              bht_dec;
  logic              clr_busy;

  modport master (
    output inv_req, wr_hold, upd_valid, upd_pc, upd_target, upd_taken, upd_inval,
    input  upd_ready, btb_we, btb_waddr, btb_wdata, bht_inc, bht_dec, clr_busy
  );

  modport slave (
    input  inv_req, wr_hold, upd_valid, upd_pc, upd_target, upd_taken, upd_inval,
    output upd_ready, btb_we, btb_waddr, btb_wdata, bht_inc, bht_dec, clr_busy
  );

endinterface

// File: rtl/btb_upd_fifo.sv
// DEPTH-entry synchronous FIFO of pending BTB updates with flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  upd_entry_t       push_data,
  input  logic             pop,
  output upd_entry_t       head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  upd_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  // A flush drops everything, including a push offered on the same edge.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/btb_update_ctrl.sv
// Owns the BTB write port: paced clear sweep after reset/invalidate, then drains
// queued branch-resolution updates and emits branch-history counter pulses.
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int unsigned IDX_W  = DEF_IDX_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = 2
) (
  input logic                clk,
  input logic                reset_n,
  btb_update_ctrl_if.slave   bus
);

  localparam int unsigned SWP_W = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  state_t            state;
  state_t            state_next;
  logic [SWP_W-1:0]  idx;
  logic [SWP_W-1:0]  idx_next;
  logic              sweep_done;

  upd_entry_t        in_entry;
  upd_entry_t        head;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              push;
  logic              pop;
  logic              ready;

  logic              we_d;
  logic [IDX_W-1:0]  waddr_d;
  logic [ADDR_W-1:0] wdata_d;
  logic              inc_d;
  logic              dec_d;
  logic              we_q;
  logic [IDX_W-1:0]  waddr_q;
  logic [ADDR_W-1:0] wdata_q;
  logic              inc_q;
  logic              dec_q;

  logic              unused_pc_hi;

  // Extra index bit flags that the last table entry has been presented.
  assign sweep_done = idx[IDX_W];

  assign ready = (count < CNT_W'(DEPTH)) && (state == RUN);
  assign push  = bus.upd_valid && ready && !bus.inv_req;

  always_comb begin
    in_entry        = '0;
    in_entry.pc     = DEF_ADDR_W'(bus.upd_pc);
    in_entry.target = DEF_ADDR_W'(bus.upd_target);
    in_entry.taken  = bus.upd_taken;
    in_entry.inval  = bus.upd_inval;
  end

  btb_upd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (bus.inv_req),
    .push      (push),
    .push_data (in_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty)
  );

  // Only the low index bits of the PC address the table.
  assign unused_pc_hi = ^head.pc[DEF_ADDR_W-1:IDX_W];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Next-state logic; invalidate restarts the sweep from any state.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    if (bus.inv_req) begin
      state_next = CLEAR;
      idx_next   = '0;
    end else if (state == CLEAR) begin
      if (sweep_done) begin
        state_next = RUN;
      end else begin
        idx_next = idx + SWP_W'(1);
      end
    end
  end

  // Output logic: next values of the write-port registers and the dequeue strobe.
  always_comb begin
    we_d    = 1'b0;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    pop     = 1'b0;
    if (!bus.inv_req) begin
      if (state == CLEAR) begin
        if (!sweep_done) begin
          we_d    = 1'b1;
          waddr_d = idx[IDX_W-1:0];
          wdata_d = ADDR_W'(BTB_INVALID);
        end
      end else if (!bus.wr_hold && !empty) begin
        pop     = 1'b1;
        we_d    = 1'b1;
        waddr_d = head.pc[IDX_W-1:0];
        wdata_d = ADDR_W'(entry_wdata(head));
        inc_d   = head.taken && !head.inval;
        dec_d   = !head.taken && !head.inval;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
    end
  end

  assign bus.btb_we    = we_q;
  assign bus.btb_waddr = waddr_q;
  assign bus.btb_wdata = wdata_q;
  assign bus.bht_inc   = inc_q;
  assign bus.bht_dec   = dec_q;
  assign bus.clr_busy  = (state == CLEAR);
  assign bus.upd_ready = ready;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Self-checking bench for btb_update_ctrl: vector table, scoreboard of expected
// table writes, and hand-written sweep, backpressure, invalidate and reset sequences.
module tb_btb_update_ctrl;
  import btb_pkg::*;

  localparam int unsigned IDX_W  = 8;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH  = 2;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] target;
    logic        taken;
    logic        inval;
    logic [7:0]  exp_addr;
    logic [15:0] exp_data;
    logic        exp_inc;
    logic        exp_dec;
  } vec_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
    logic        inc;
    logic        dec;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  btb_update_ctrl_if #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) bus ();

  btb_update_ctrl #(
    .IDX_W  (IDX_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  wr_t  sb[$];
  vec_t vecs[6];
  int   sweep_exp = 0;
  logic prev_busy = 1'b1;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Observes every write: sweep writes by address order, update writes against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.btb_we && bus.clr_busy) begin
        check("sweep_write", 32'({bus.btb_waddr, bus.btb_wdata, bus.bht_inc, bus.bht_dec}),
              32'({sweep_exp[7:0], 16'h0000, 2'b00}));
        sweep_exp++;
      end else if (bus.btb_we) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write at %0t",
                   bus.btb_waddr, bus.btb_wdata, $time);
        end else begin
          wr_t e;
          e = sb.pop_front();
          check("update_write", 32'({bus.btb_waddr, bus.btb_wdata, bus.bht_inc, bus.bht_dec}), 32'(e));
        end
      end else begin
        check("idle_no_pulse", 32'({bus.bht_inc, bus.bht_dec}), 32'd0);
        if (bus.clr_busy) sweep_exp = 0;
      end
      if (prev_busy && !bus.clr_busy) check("sweep_length", 32'(sweep_exp), 32'd256);
      prev_busy = bus.clr_busy;
    end
  end

  task automatic wait_busy_fall(input string name);
    int n = 0;
    while (bus.clr_busy && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(n), 32'd257);
  endtask

  task automatic drive(input logic [15:0] pc, input logic [15:0] tgt, input logic tk, input logic inv);
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = pc;
    bus.upd_target = tgt;
    bus.upd_taken  = tk;
    bus.upd_inval  = inv;
  endtask

  task automatic inv_case(input int n_fill);
    @(negedge clk);
    bus.wr_hold = 1'b1;
    for (int k = 0; k < n_fill; k++) begin
      drive(16'h0500 + 16'(k), 16'h0600 + 16'(k), 1'b1, 1'b0);
      sb.push_back(wr_t'({8'(k), 16'h0600 + 16'(k), 2'b10}));
      @(negedge clk);
    end
    check("inv_ready_before", 32'(bus.upd_ready), 32'(n_fill < int'(DEPTH)));
    drive(16'h0577, 16'h0678, 1'b0, 1'b0);
    bus.inv_req = 1'b1;
    bus.wr_hold = 1'b0;
    @(posedge clk); #1;
    bus.inv_req   = 1'b0;
    bus.upd_valid = 1'b0;
    sb.delete();
    check("inv_busy", 32'(bus.clr_busy), 32'd1);
    check("inv_we_idle", 32'(bus.btb_we), 32'd0);
    check("inv_ready_low", 32'(bus.upd_ready), 32'd0);
    wait_busy_fall("inv_sweep_len");
    check("inv_ready_after", 32'(bus.upd_ready), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h0123, 16'h0040, 1'b1, 1'b0, 8'h23, 16'h0040, 1'b1, 1'b0};
    vecs[1] = '{16'h0010, 16'h0011, 1'b0, 1'b0, 8'h10, 16'h0011, 1'b0, 1'b1};
    vecs[2] = '{16'h0010, 16'h1234, 1'b1, 1'b1, 8'h10, 16'h0000, 1'b0, 1'b0};
    vecs[3] = '{16'hABFF, 16'h0000, 1'b1, 1'b0, 8'hFF, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{16'h0200, 16'hBEEF, 1'b0, 1'b1, 8'h00, 16'h0000, 1'b0, 1'b0};
    vecs[5] = '{16'h7F80, 16'hFFFF, 1'b0, 1'b0, 8'h80, 16'hFFFF, 1'b0, 1'b1};

    bus.inv_req    = 1'b0;
    bus.wr_hold    = 1'b0;
    bus.upd_valid  = 1'b0;
    bus.upd_pc     = '0;
    bus.upd_target = '0;
    bus.upd_taken  = 1'b0;
    bus.upd_inval  = 1'b0;

    // Reset values and initial sweep
    repeat (3) @(negedge clk);
    check("rst_write_regs", 32'({bus.btb_we, bus.btb_waddr, bus.btb_wdata, bus.bht_inc, bus.bht_dec}), 32'd0);
    check("rst_busy", 32'(bus.clr_busy), 32'd1);
    check("rst_ready", 32'(bus.upd_ready), 32'd0);
    mon_en  = 1'b1;
    reset_n = 1'b1;
    wait_busy_fall("reset_sweep_len");
    check("ready_at_busy_fall", 32'(bus.upd_ready), 32'd1);
    check("we_at_busy_fall", 32'(bus.btb_we), 32'd0);

    // Table-driven single updates: one-edge latency and one-cycle pulses
    foreach (vecs[i]) begin
      @(negedge clk);
      check("vec_ready", 32'(bus.upd_ready), 32'd1);
      drive(vecs[i].pc, vecs[i].target, vecs[i].taken, vecs[i].inval);
      sb.push_back(wr_t'({vecs[i].exp_addr, vecs[i].exp_data, vecs[i].exp_inc, vecs[i].exp_dec}));
      @(posedge clk); #1;
      bus.upd_valid = 1'b0;
      check("vec_no_write_at_accept", 32'(bus.btb_we), 32'd0);
      @(posedge clk); #1;
      check("vec_latency", 32'({bus.btb_we, bus.bht_inc, bus.bht_dec}),
            32'({1'b1, vecs[i].exp_inc, vecs[i].exp_dec}));
      @(posedge clk); #1;
      check("vec_one_cycle", 32'({bus.btb_we, bus.bht_inc, bus.bht_dec}), 32'd0);
    end

    // Back-to-back updates at one per cycle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_ready", 32'(bus.upd_ready), 32'd1);
      if (i >= 2) check("b2b_we_continuous", 32'(bus.btb_we), 32'd1);
      drive(16'h1001 * 16'(i + 1), 16'h0A00 + 16'(i), (i % 2) == 0, 1'b0);
      sb.push_back(wr_t'({8'(i + 1), 16'h0A00 + 16'(i), (i % 2) == 0, (i % 2) == 1}));
    end
    @(negedge clk);
    bus.upd_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Backpressure with wr_hold
    bus.wr_hold = 1'b1;
    drive(16'h0031, 16'h0131, 1'b1, 1'b0);
    check("bp_ready_a", 32'(bus.upd_ready), 32'd1);
    sb.push_back(wr_t'({8'h31, 16'h0131, 2'b10}));
    @(negedge clk);
    drive(16'h0032, 16'h0132, 1'b0, 1'b0);
    check("bp_ready_b", 32'(bus.upd_ready), 32'd1);
    sb.push_back(wr_t'({8'h32, 16'h0132, 2'b01}));
    @(negedge clk);
    drive(16'h0033, 16'h0133, 1'b1, 1'b1);
    check("bp_ready_full", 32'(bus.upd_ready), 32'd0);
    check("bp_hold_no_write", 32'(bus.btb_we), 32'd0);
    @(negedge clk);
    check("bp_ready_still_full", 32'(bus.upd_ready), 32'd0);
    check("bp_hold_no_write2", 32'(bus.btb_we), 32'd0);
    bus.wr_hold = 1'b0;
    @(posedge clk); #1;
    check("bp_first_dequeue", 32'(bus.btb_we), 32'd1);
    check("bp_ready_returns", 32'(bus.upd_ready), 32'd1);
    sb.push_back(wr_t'({8'h33, 16'h0000, 2'b00}));
    @(posedge clk); #1;
    bus.upd_valid = 1'b0;
    check("bp_second_dequeue", 32'(bus.btb_we), 32'd1);
    @(posedge clk); #1;
    check("bp_third_dequeue", 32'(bus.btb_we), 32'd1);
    @(posedge clk); #1;
    check("bp_drained", 32'(bus.btb_we), 32'd0);

    // Invalidate mid-traffic: FIFO full, then FIFO with room
    inv_case(2);
    inv_case(1);

    // Reset in the middle of a sweep
    @(negedge clk);
    bus.inv_req = 1'b1;
    @(posedge clk); #1;
    bus.inv_req = 1'b0;
    begin
      int n = 0;
      while (!(bus.btb_we && bus.btb_waddr == 8'd100) && n < 400) begin
        @(posedge clk); #1;
        n++;
      end
      check("reach_idx100", 32'(bus.btb_waddr), 32'd100);
    end
    #2 reset_n = 1'b0;
    #1;
    check("midrst_write_regs", 32'({bus.btb_we, bus.btb_waddr, bus.btb_wdata, bus.bht_inc, bus.bht_dec}), 32'd0);
    check("midrst_busy", 32'(bus.clr_busy), 32'd1);
    check("midrst_ready", 32'(bus.upd_ready), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_busy_fall("restart_sweep_len");
    check("ready_after_restart", 32'(bus.upd_ready), 32'd1);

    // One more update after the restarted sweep
    @(negedge clk);
    drive(16'h0456, 16'h0789, 1'b1, 1'b0);
    sb.push_back(wr_t'({8'h56, 16'h0789, 2'b10}));
    @(negedge clk);
    bus.upd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
